// File: rtl/store_queue.sv
// Speculative store queue: in-order enqueue, commit and flush of speculative
// entries, in-order drain of committed entries to the data cache, and
// byte-wise store-to-load forwarding.
module store_queue #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,

    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [3:0]               st_wstrb,
    input  logic [31:0]              st_wdata,

    input  logic                     commit_valid,
    output logic                     commit_ready,

    input  logic                     ld_valid,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic [3:0]               ld_hit_mask,
    output logic [31:0]              ld_data,

    output logic                     dcache_req,
    output logic                     dcache_wr,
    output logic [3:0]               dcache_wstrb,
    output logic [ADDR_W-1:0]        dcache_addr,
    output logic [31:0]              dcache_wdata,
    input  logic                     dcache_addr_ok,
    input  logic                     dcache_data_ok,

    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        wstrb;
        logic [31:0]       wdata;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
    } state_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   head_q, cmt_q, tail_q;
    logic [PW-1:0]   head_d, cmt_d, tail_d;
    logic [PW-1:0]   count_c;
    state_t          state_q, state_d;
    logic            enq;
    logic            cmt_fire;
    logic            pop;
    entry_t          head_e;
    logic            unused_ld_lsb;

    assign unused_ld_lsb = ^ld_addr[1:0];

    // Occupancy and handshake status, all derived from registered pointers
    assign count_c      = tail_q - head_q;
    assign count        = count_c;
    assign empty        = (count_c == '0);
    assign st_ready     = (count_c < PW'(DEPTH));
    assign commit_ready = (cmt_q != tail_q);

    // Pointer next-state: a same-cycle commit is honoured before flush trims tail
    always_comb begin
        enq      = st_valid && st_ready && !flush;
        cmt_fire = commit_valid && commit_ready;
        cmt_d    = cmt_q + PW'(cmt_fire);
        tail_d   = flush ? cmt_d : (tail_q + PW'(enq));
        head_d   = head_q + PW'(pop);
    end

    // Drain FSM next-state and dcache control
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        dcache_req = 1'b0;
        dcache_wr  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (head_q != cmt_q) state_d = S_ADDR;
            end
            S_ADDR: begin
                dcache_req = 1'b1;
                dcache_wr  = 1'b1;
                if (dcache_addr_ok) state_d = S_DATA;
            end
            S_DATA: begin
                if (dcache_data_ok) begin
                    state_d = S_IDLE;
                    pop     = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pointer and FSM state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            cmt_q   <= '0;
            tail_q  <= '0;
            state_q <= S_IDLE;
        end else begin
            head_q  <= head_d;
            cmt_q   <= cmt_d;
            tail_q  <= tail_d;
            state_q <= state_d;
        end
    end

    // Entry storage; occupancy is tracked by the pointers so no reset is needed
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[tail_q[IW-1:0]] <= entry_t'({st_addr, st_wstrb, st_wdata});
        end
    end

    // Head entry is presented only while the address phase is active
    assign head_e       = mem[head_q[IW-1:0]];
    assign dcache_addr  = dcache_req ? head_e.addr  : '0;
    assign dcache_wstrb = dcache_req ? head_e.wstrb : '0;
    assign dcache_wdata = dcache_req ? head_e.wdata : '0;

    // Forwarding: walk oldest to youngest so the youngest matching byte wins
    always_comb begin
        entry_t e;
        ld_hit_mask = '0;
        ld_data     = '0;
        e           = '0;
        if (ld_valid) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                e = mem[IW'(head_q[IW-1:0] + IW'(k))];
                if ((PW'(k) < count_c) && (e.addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
                    for (int unsigned b = 0; b < 4; b++) begin
                        if (e.wstrb[b]) begin
                            ld_hit_mask[b]   = 1'b1;
                            ld_data[8*b +: 8] = e.wdata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: fill/full, forwarding, commit/flush
// interplay, drain ordering across pointer wrap, and reset mid-transaction.
module tb_store_queue;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [3:0]        st_wstrb;
    logic [31:0]       st_wdata;
    logic              commit_valid;
    logic              commit_ready;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [3:0]        ld_hit_mask;
    logic [31:0]       ld_data;
    logic              dcache_req;
    logic              dcache_wr;
    logic [3:0]        dcache_wstrb;
    logic [ADDR_W-1:0] dcache_addr;
    logic [31:0]       dcache_wdata;
    logic              dcache_addr_ok;
    logic              dcache_data_ok;
    logic [3:0]        count;
    logic              empty;

    int n_vec = 0;
    int n_err = 0;

    store_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_addr        (st_addr),
        .st_wstrb       (st_wstrb),
        .st_wdata       (st_wdata),
        .commit_valid   (commit_valid),
        .commit_ready   (commit_ready),
        .ld_valid       (ld_valid),
        .ld_addr        (ld_addr),
        .ld_hit_mask    (ld_hit_mask),
        .ld_data        (ld_data),
        .dcache_req     (dcache_req),
        .dcache_wr      (dcache_wr),
        .dcache_wstrb   (dcache_wstrb),
        .dcache_addr    (dcache_addr),
        .dcache_wdata   (dcache_wdata),
        .dcache_addr_ok (dcache_addr_ok),
        .dcache_data_ok (dcache_data_ok),
        .count          (count),
        .empty          (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_wstrb = s;
        st_wdata = d;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic commit_n(input int n);
        commit_valid = 1'b1;
        repeat (n) tick();
        commit_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_req();
        int i = 0;
        while (!dcache_req && i < 16) begin
            tick();
            i++;
        end
        chk("drain_req", 64'(dcache_req), 64'd1);
    endtask

    // One full drain handshake, checking the presented entry
    task automatic drain(input logic [31:0] a, input logic [31:0] d);
        wait_req();
        chk("drain_addr", 64'(dcache_addr), 64'(a));
        chk("drain_wdata", 64'(dcache_wdata), 64'(d));
        dcache_addr_ok = 1'b1;
        tick();
        dcache_addr_ok = 1'b0;
        chk("drain_req_low", 64'(dcache_req), 64'd0);
        dcache_data_ok = 1'b1;
        tick();
        dcache_data_ok = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; flush = 1'b0; st_valid = 1'b0; st_addr = '0; st_wstrb = '0;
        st_wdata = '0; commit_valid = 1'b0; ld_valid = 1'b1; ld_addr = '0;
        dcache_addr_ok = 1'b0; dcache_data_ok = 1'b0;
        repeat (2) tick();

        // Reset state
        chk("rst_st_ready", 64'(st_ready), 64'd1);
        chk("rst_commit_ready", 64'(commit_ready), 64'd0);
        chk("rst_dcache_req", 64'(dcache_req), 64'd0);
        chk("rst_dcache_wr", 64'(dcache_wr), 64'd0);
        chk("rst_hit_mask", 64'(ld_hit_mask), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        reset = 1'b0;
        tick();

        // Fill to DEPTH with no commits
        for (int i = 0; i < 8; i++) begin
            chk("fill_ready", 64'(st_ready), 64'd1);
            enq(32'h200 + 32'(4 * i), 4'hF, 32'h1000 + 32'(i));
            chk("fill_count", 64'(count), 64'(i + 1));
        end
        chk("full_st_ready", 64'(st_ready), 64'd0);
        enq(32'h220, 4'hF, 32'hBAD0_0000);
        chk("full_count_hold", 64'(count), 64'd8);
        chk("full_no_req", 64'(dcache_req), 64'd0);
        ld_addr = 32'h20C; #1;
        chk("full_fwd_mask", 64'(ld_hit_mask), 64'hF);
        chk("full_fwd_data", 64'(ld_data), 64'h1003);
        ld_addr = 32'h220; #1;
        chk("full_drop_mask", 64'(ld_hit_mask), 64'd0);
        do_flush();
        chk("full_flush_count", 64'(count), 64'd0);
        chk("full_flush_empty", 64'(empty), 64'd1);

        // Byte merge forwarding
        enq(32'h100, 4'hF, 32'h1122_3344);
        enq(32'h101, 4'h2, 32'h0000_AA00);
        ld_addr = 32'h100; #1;
        chk("merge_mask", 64'(ld_hit_mask), 64'hF);
        chk("merge_data", 64'(ld_data), 64'h1122_AA44);
        ld_addr = 32'h104; #1;
        chk("miss_mask", 64'(ld_hit_mask), 64'd0);
        chk("miss_data", 64'(ld_data), 64'd0);
        ld_valid = 1'b0; ld_addr = 32'h100; #1;
        chk("ldoff_mask", 64'(ld_hit_mask), 64'd0);
        chk("ldoff_data", 64'(ld_data), 64'd0);
        ld_valid = 1'b1;
        enq(32'h108, 4'h1, 32'h0000_00EE);
        ld_addr = 32'h10A; #1;
        chk("partial_mask", 64'(ld_hit_mask), 64'h1);
        chk("partial_data", 64'(ld_data), 64'hEE);

        // Entry enqueued this cycle is not yet visible
        st_valid = 1'b1; st_addr = 32'h300; st_wstrb = 4'hF; st_wdata = 32'h5566_7788;
        ld_addr = 32'h300; #1;
        chk("same_cycle_mask", 64'(ld_hit_mask), 64'd0);
        tick();
        st_valid = 1'b0; #1;
        chk("next_cycle_mask", 64'(ld_hit_mask), 64'hF);
        chk("next_cycle_data", 64'(ld_data), 64'h5566_7788);
        do_flush();
        chk("spec_flush_count", 64'(count), 64'd0);
        ld_addr = 32'h100; #1;
        chk("spec_flush_mask", 64'(ld_hit_mask), 64'd0);

        // Enqueue 3, commit 1, flush; committed entry drains
        enq(32'h400, 4'hF, 32'h4040_4040);
        enq(32'h404, 4'hF, 32'h4141_4141);
        enq(32'h408, 4'hF, 32'h4242_4242);
        commit_n(1);
        do_flush();
        chk("cf_count", 64'(count), 64'd1);
        chk("cf_commit_ready", 64'(commit_ready), 64'd0);
        chk("cf_req", 64'(dcache_req), 64'd1);
        chk("cf_wr", 64'(dcache_wr), 64'd1);
        chk("cf_addr", 64'(dcache_addr), 64'h400);
        chk("cf_wstrb", 64'(dcache_wstrb), 64'hF);
        chk("cf_wdata", 64'(dcache_wdata), 64'h4040_4040);
        dcache_addr_ok = 1'b1;
        tick();
        dcache_addr_ok = 1'b0;
        chk("cf_data_req", 64'(dcache_req), 64'd0);
        ld_addr = 32'h400; #1;
        chk("cf_drain_fwd", 64'(ld_hit_mask), 64'hF);
        tick();
        chk("cf_wait_count", 64'(count), 64'd1);
        dcache_data_ok = 1'b1;
        tick();
        dcache_data_ok = 1'b0;
        chk("cf_done_empty", 64'(empty), 64'd1);
        chk("cf_done_count", 64'(count), 64'd0);

        // Commit and flush in the same cycle
        enq(32'h500, 4'hF, 32'h5000_000A);
        enq(32'h504, 4'hF, 32'h5000_000B);
        commit_valid = 1'b1; flush = 1'b1;
        tick();
        commit_valid = 1'b0; flush = 1'b0;
        chk("cmf_count", 64'(count), 64'd1);
        chk("cmf_commit_ready", 64'(commit_ready), 64'd0);
        drain(32'h500, 32'h5000_000A);
        chk("cmf_empty", 64'(empty), 64'd1);

        // Full queue, drain completes with st_valid held high
        for (int i = 0; i < 8; i++) enq(32'h600 + 32'(4 * i), 4'hF, 32'h6000_0000 + 32'(i));
        commit_n(8);
        chk("fd_count", 64'(count), 64'd8);
        chk("fd_ready", 64'(st_ready), 64'd0);
        wait_req();
        chk("fd_addr", 64'(dcache_addr), 64'h600);
        st_valid = 1'b1; st_addr = 32'h700; st_wstrb = 4'hF; st_wdata = 32'h7000_0000;
        dcache_addr_ok = 1'b1;
        tick();
        dcache_addr_ok = 1'b0;
        chk("fd_data_count", 64'(count), 64'd8);
        dcache_data_ok = 1'b1;
        tick();
        dcache_data_ok = 1'b0;
        chk("fd_no_bypass_count", 64'(count), 64'd7);
        chk("fd_ready_rise", 64'(st_ready), 64'd1);
        tick();
        st_valid = 1'b0;
        chk("fd_accept_count", 64'(count), 64'd8);
        commit_n(1);
        for (int i = 1; i < 8; i++) drain(32'h600 + 32'(4 * i), 32'h6000_0000 + 32'(i));
        drain(32'h700, 32'h7000_0000);
        chk("fd_empty", 64'(empty), 64'd1);

        // 20 stores in batches of 4 so pointers wrap past 2*DEPTH
        for (int b = 0; b < 5; b++) begin
            for (int j = 0; j < 4; j++) enq(32'h800 + 32'(16 * b + 4 * j), 4'hF, 32'hA000_0000 + 32'(4 * b + j));
            chk("wrap_count", 64'(count), 64'd4);
            commit_n(4);
            for (int j = 0; j < 4; j++) drain(32'h800 + 32'(16 * b + 4 * j), 32'hA000_0000 + 32'(4 * b + j));
        end
        chk("wrap_empty", 64'(empty), 64'd1);

        // Reset while in the data phase
        enq(32'h900, 4'hF, 32'hDEAD_0001);
        commit_n(1);
        wait_req();
        dcache_addr_ok = 1'b1;
        tick();
        dcache_addr_ok = 1'b0;
        ld_addr = 32'h900;
        reset = 1'b1; #1;
        chk("mid_rst_req", 64'(dcache_req), 64'd0);
        chk("mid_rst_wr", 64'(dcache_wr), 64'd0);
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_empty", 64'(empty), 64'd1);
        chk("mid_rst_st_ready", 64'(st_ready), 64'd1);
        chk("mid_rst_commit_ready", 64'(commit_ready), 64'd0);
        chk("mid_rst_hit_mask", 64'(ld_hit_mask), 64'd0);
        tick();
        reset = 1'b0;
        dcache_data_ok = 1'b1;
        tick();
        dcache_data_ok = 1'b0;
        chk("post_rst_count", 64'(count), 64'd0);
        chk("post_rst_req", 64'(dcache_req), 64'd0);
        enq(32'hA00, 4'h3, 32'h0000_BEEF);
        commit_n(1);
        drain(32'hA00, 32'h0000_BEEF);
        chk("post_rst_empty", 64'(empty), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/store_queue.md
STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of store entries (power of two, 2..32).
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width; data width SHALL be fixed at 32 with 4 byte strobes.
REQ-003 SHALL have port clk  in  1  sole clock, all state updated on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port flush  in  1  discard all uncommitted (speculative) entries.
REQ-006 SHALL have ports st_valid in 1, st_ready out 1, st_addr in ADDR_W, st_wstrb in 4, st_wdata in 32  enqueue of a speculative store.
REQ-007 SHALL have ports commit_valid in 1, commit_ready out 1  retire the oldest speculative entry.
REQ-008 SHALL have ports ld_valid in 1, ld_addr in ADDR_W, ld_hit_mask out 4, ld_data out 32  load forwarding lookup.
REQ-009 SHALL have ports dcache_req out 1, dcache_wr out 1, dcache_wstrb out 4, dcache_addr out ADDR_W, dcache_wdata out 32, dcache_addr_ok in 1, dcache_data_ok in 1  data-cache write port.
REQ-010 SHALL have ports count out clog2(DEPTH)+1 (occupied entries) and empty out 1.

Function
REQ-011 SHALL hold a circular buffer with head (oldest), cmt (first speculative) and tail (next free) pointers of width clog2(DEPTH)+1, wrapping modulo 2*DEPTH; entries head..cmt-1 committed, cmt..tail-1 speculative.
REQ-012 SHALL drive st_ready = (count < DEPTH), from registered state only; no enqueue bypass when full, even if an entry drains the same cycle.
REQ-013 SHALL on st_valid && st_ready && !flush write {addr, wstrb, wdata} at tail and increment tail.
REQ-014 SHALL drive commit_ready = (cmt != tail); on commit_valid && commit_ready increment cmt; commit_valid with commit_ready=0 SHALL be ignored.
REQ-015 SHALL on flush set tail to cmt after any same-cycle commit (commit honoured, then discard); enqueue in the flush cycle SHALL be dropped; committed entries SHALL be unaffected.
REQ-016 SHALL drain committed entries in order via FSM IDLE/ADDR/DATA: IDLE->ADDR when head != cmt; ADDR->DATA on dcache_addr_ok; DATA->IDLE on dcache_data_ok, incrementing head that cycle.
REQ-017 SHALL in ADDR drive dcache_req=1, dcache_wr=1 and the head entry's addr/wstrb/data; dcache_req SHALL be 0 in IDLE and DATA; at most one transaction outstanding.
REQ-018 SHALL be unaffected by flush in ADDR/DATA states (the draining entry is committed).
REQ-019 SHALL compute ld_hit_mask/ld_data combinationally in the same cycle over all occupied entries (committed, speculative, draining until data_ok) matching ld_addr[ADDR_W-1:2]; per byte, the youngest matching entry with that strobe set SHALL supply the byte.
REQ-020 SHALL drive ld_hit_mask=0 and ld_data=0 when ld_valid=0; bytes with hit_mask bit 0 SHALL read 0.
REQ-021 SHALL exclude an entry enqueued in the current cycle from forwarding (visible from next cycle).
REQ-022 SHALL compute count = tail - head (modulo pointer width), empty = (count == 0).

Reset
REQ-023 SHALL on reset, asynchronously, set head=cmt=tail=0, FSM=IDLE; outputs: st_ready=1, commit_ready=0, dcache_req=0, dcache_wr=0, ld_hit_mask=0, count=0, empty=1.
REQ-024 SHALL not require entry storage to be reset; unoccupied entries SHALL never affect any output.
REQ-025 SHALL abort any in-progress dcache transaction state on reset mid-operation; the first post-reset cycle SHALL show dcache_req=0.

Verification
REQ-026 Enqueue 8 stores (DEPTH=8) with no commits -> st_ready=0 after 8th, count=8, 9th st_valid ignored, dcache_req stays 0.
REQ-027 Enqueue sw 0x100 data 0x11223344 wstrb 0xF, then sb 0x101 data 0x0000AA00 wstrb 0x2; ld 0x100 -> hit_mask 0xF, ld_data 0x1122AA44.
REQ-028 Enqueue 3, commit 1, flush -> count=1, commit_ready=0, committed entry drained: dcache_req with addr_ok=1 next cycle, data_ok 2 cycles later -> empty=1.
REQ-029 Commit and flush same cycle with 2 speculative entries -> both committed entry retained, second discarded, count=1.
REQ-030 Full queue, drain completes (data_ok) with st_valid high -> st_ready rises the cycle after, enqueue accepted then; pointers wrap past 2*DEPTH over 20 stores with correct drain order.
REQ-031 Assert reset while FSM in DATA -> all outputs at reset values immediately, no head increment on later data_ok.
